fetch_ctrl: RTL

Sequencer for the program-counter register and instruction-memory fetch port of the Mini-MIPS core. It computes the `target` fed into the PC register every cycle, so it decides when the PC holds, increments by 4, or jumps to a redirect address. It also runs a req/ack handshake with instruction memory and presents one fetched instruction at a time to decode, with stall, redirect (branch/jump) and halt control.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_ctrl_if.sv | 15 +
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the Mini-MIPS fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_M4      = 32'hFFFF_FFFC;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch port between fetch_ctrl (master) and imem (slave).
interface fetch_ctrl_if;
  // imem_req rises in FETCH and stays high with imem_addr stable until a cycle
  // in which imem_ack is high; that cycle carries imem_rdata and completes the
  // transfer. Only reset may drop imem_req before the ack.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and imem fetch handshake for the Mini-MIPS core.
// Build option: FETCH_CTRL_ALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_cur,
  output logic [31:0]         target,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic                trap,
  output fetch_state_t        dbg_state
);

`ifdef FETCH_CTRL_ALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;
  logic         trap_q, trap_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         req;

  // A live redirect wins over a stored one when both meet an ack.
  logic [31:0]  redir_src;
  logic         redir_mis;
  logic [31:0]  redir_pc;

  assign redir_src = redirect ? redirect_pc : pend_pc_q;
  assign redir_mis = TRAP_EN && (redir_src[1:0] != 2'b00);
  assign redir_pc  = redir_mis ? TRAP_VEC :
                     (TRAP_EN ? redir_src : {redir_src[31:2], 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= START;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      trap_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      trap_q        <= trap_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    target        = pc_cur;
    req           = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    trap_d        = 1'b0;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;

    case (state_q)
      START: begin
        target  = pc_cur + PC_INC;
        state_d = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          // Data fetched from a path that was redirected away from is dropped.
          if (pend_q || redirect) begin
            target = redir_pc;
            trap_d = redir_mis;
            pend_d = 1'b0;
          end else begin
            instr_d       = imem.imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = ISSUE;
          end
        end else if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      ISSUE: begin
        if (redirect) begin
          target        = redir_pc;
          trap_d        = redir_mis;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (halt) begin
          instr_valid_d = 1'b0;
          halted_d      = 1'b1;
          state_d       = HALT;
        end else if (!stall) begin
          target        = pc_cur + PC_INC;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = START;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_cur;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign halted         = halted_q;
  assign trap           = trap_q;
  assign dbg_state      = state_q;

endmodule
